// File: rtl/quad_pkg.sv
// ---------------------------------------------------------------------------
// quad_pkg
// Shared types and constants for the quadrature decoder:
//   - state_t   : decoder FSM states (INIT while the pins settle, RUN to decode)
//   - S00..S01  : 2-bit {A,B} phase states in up-count order
//   - DIR_UP/DIR_DOWN : encoding of the dir output
//   - trans_t / classify() : classification of one filtered phase transition
// ---------------------------------------------------------------------------
package quad_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [1:0] S00 = 2'b00;
    localparam logic [1:0] S10 = 2'b10;
    localparam logic [1:0] S11 = 2'b11;
    localparam logic [1:0] S01 = 2'b01;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef enum logic [1:0] {
        TR_NONE    = 2'd0,
        TR_UP      = 2'd1,
        TR_DOWN    = 2'd2,
        TR_ILLEGAL = 2'd3
    } trans_t;

    // Up order with A leading is 00 -> 10 -> 11 -> 01 -> 00. Any single-bit
    // change not on that list is necessarily a step in the reverse order.
    function automatic trans_t classify(input logic [1:0] prev,
                                        input logic [1:0] cur);
        trans_t t;
        t = TR_NONE;
        if (prev != cur) begin
            if ((prev ^ cur) == 2'b11) begin
                t = TR_ILLEGAL;
            end else begin
                case ({prev, cur})
                    {S00, S10},
                    {S10, S11},
                    {S11, S01},
                    {S01, S00}: t = TR_UP;
                    default:    t = TR_DOWN;
                endcase
            end
        end
        return t;
    endfunction

endpackage

// File: rtl/quad_filter.sv
// ---------------------------------------------------------------------------
// quad_filter
// One encoder channel: 2-FF synchronizer followed by a stability filter.
// The filtered level only follows the synchronized level after it has
// differed for FILTER_LEN consecutive cycles; shorter glitches are dropped.
// Ports:
//   clock   : system clock
//   reset   : asynchronous active-high reset, clears all state
//   pin_i   : raw asynchronous pin
//   level_o : filtered, synchronous level
// ---------------------------------------------------------------------------
module quad_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic pin_i,
    output logic level_o
);

    // Counter only needs to hold 0 .. FILTER_LEN-1.
    localparam int CNT_W = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            // Reaching FILTER_LEN commits the new level; counter drops back to 0.
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= pin_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/quad_decoder.sv
// ---------------------------------------------------------------------------
// quad_decoder
// Incremental encoder front end: filters phases A/B, decodes each filtered
// transition into a one-cycle step pulse plus direction, and keeps a
// wrapping position count. Illegal (double) transitions set a sticky error.
// Ports:
//   clock      : system clock
//   reset      : asynchronous active-high reset
//   quad_a/b   : raw encoder phases (asynchronous)
//   counter_en : 1 lets steps move position, 0 holds it
//   clear      : synchronous clear of position and error
//   step       : one-cycle pulse per valid transition
//   dir        : direction of the last valid step (1 = up)
//   position   : WIDTH-bit wrapping count
//   error      : sticky illegal-transition flag
// ---------------------------------------------------------------------------
module quad_decoder
    import quad_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int FILTER_LEN = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             quad_a,
    input  logic             quad_b,
    input  logic             counter_en,
    input  logic             clear,
    output logic             step,
    output logic             dir,
    output logic [WIDTH-1:0] position,
    output logic             error
);

    // INIT spans FILTER_LEN+3 cycles: enough for a pin level present at reset
    // release to cross the synchronizer and filter and land in prev_q.
    localparam int INIT_LAST = FILTER_LEN + 2;
    localparam int INIT_W    = $clog2(INIT_LAST + 1);
    localparam logic [INIT_W-1:0] INIT_END = INIT_W'(INIT_LAST);

    logic             filt_a;
    logic             filt_b;
    logic [1:0]       phase_cur;
    trans_t           trans;

    state_t           state_q;
    state_t           state_d;
    logic [INIT_W-1:0] init_cnt_q;
    logic [INIT_W-1:0] init_cnt_d;

    logic [1:0]       prev_q;
    logic             step_q;
    logic             step_d;
    logic             dir_q;
    logic             dir_d;
    logic [WIDTH-1:0] pos_q;
    logic [WIDTH-1:0] pos_d;
    logic             err_q;
    logic             err_d;

    quad_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
        .clock   (clock),
        .reset   (reset),
        .pin_i   (quad_a),
        .level_o (filt_a)
    );

    quad_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
        .clock   (clock),
        .reset   (reset),
        .pin_i   (quad_b),
        .level_o (filt_b)
    );

    assign phase_cur = {filt_a, filt_b};

    // FSM next state: INIT counts out its settling window, RUN is terminal.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            INIT: begin
                if (init_cnt_q == INIT_END) begin
                    state_d    = RUN;
                    init_cnt_d = '0;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d    = INIT;
                init_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    // Decode: only RUN produces steps or errors. clear overrides the
    // position/error update but leaves step/dir reporting intact.
    always_comb begin
        trans  = classify(prev_q, phase_cur);
        step_d = 1'b0;
        dir_d  = dir_q;
        pos_d  = pos_q;
        err_d  = err_q;
        if (state_q == RUN) begin
            case (trans)
                TR_UP: begin
                    step_d = 1'b1;
                    dir_d  = DIR_UP;
                    if (counter_en) pos_d = pos_q + WIDTH'(1);
                end
                TR_DOWN: begin
                    step_d = 1'b1;
                    dir_d  = DIR_DOWN;
                    if (counter_en) pos_d = pos_q - WIDTH'(1);
                end
                TR_ILLEGAL: begin
                    err_d = 1'b1;
                end
                default: begin
                end
            endcase
        end
        if (clear) begin
            pos_d = '0;
            err_d = 1'b0;
        end
    end

    // prev_q follows the filtered phase every cycle, in INIT and on errors.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_q <= S00;
            step_q <= 1'b0;
            dir_q  <= DIR_DOWN;
            pos_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            prev_q <= phase_cur;
            step_q <= step_d;
            dir_q  <= dir_d;
            pos_q  <= pos_d;
            err_q  <= err_d;
        end
    end

    assign step     = step_q;
    assign dir      = dir_q;
    assign position = pos_q;
    assign error    = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
`timescale 1ns/1ps
module tb_quad_decoder;

    localparam int WIDTH = 8;
    localparam int FL    = 3;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             quad_a = 1'b0;
    logic             quad_b = 1'b0;
    logic             counter_en = 1'b0;
    logic             clear = 1'b0;
    logic             step;
    logic             dir;
    logic [WIDTH-1:0] position;
    logic             error;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;
    int step_seen = 0;

    always #5 clock = ~clock;

    quad_decoder #(.WIDTH(WIDTH), .FILTER_LEN(FL)) dut (
        .clock      (clock),
        .reset      (reset),
        .quad_a     (quad_a),
        .quad_b     (quad_b),
        .counter_en (counter_en),
        .clear      (clear),
        .step       (step),
        .dir        (dir),
        .position   (position),
        .error      (error)
    );

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    // Pins pass through two sample delays; a channel's filtered level adopts
    // the synchronized level once the last FL synchronized samples all
    // disagree with it. Phase states map to a position on a 4-step circle;
    // the circular distance between consecutive filtered states gives the
    // event: 1 = up, 3 = down, 2 = illegal.
    logic             pa1, pa2, pb1, pb2;
    logic             ha[$];
    logic             hb[$];
    logic             fa, fb;
    logic [1:0]       m_prev;
    int               m_edges;
    logic             m_step, m_dir, m_err;
    logic [WIDTH-1:0] m_pos;

    function automatic int phase_idx(input logic [1:0] s);
        case (s)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic filt_next(input logic f, input logic h[$]);
        if (h.size() < FL) return f;
        for (int i = h.size() - FL; i < h.size(); i++)
            if (h[i] == f) return f;
        return h[h.size()-1];
    endfunction

    task automatic model_reset();
        pa1 = 0; pa2 = 0; pb1 = 0; pb2 = 0;
        ha.delete(); hb.delete();
        fa = 0; fb = 0; m_prev = 2'b00; m_edges = 0;
        m_step = 0; m_dir = 0; m_err = 0; m_pos = '0;
    endtask

    task automatic model_edge();
        logic [1:0] cur;
        bit         run;
        int         d;
        cur = {fa, fb};
        run = (m_edges >= FL + 3);
        if (m_edges < 1000) m_edges++;
        d = (phase_idx(cur) - phase_idx(m_prev) + 4) % 4;
        m_step = 0;
        if (run && d == 1) begin
            m_step = 1; m_dir = 1;
            if (counter_en) m_pos = m_pos + 1'b1;
        end else if (run && d == 3) begin
            m_step = 1; m_dir = 0;
            if (counter_en) m_pos = m_pos - 1'b1;
        end else if (run && d == 2) begin
            m_err = 1;
        end
        if (clear) begin
            m_pos = '0; m_err = 0;
        end
        m_prev = cur;
        ha.push_back(pa2); if (ha.size() > FL) void'(ha.pop_front());
        hb.push_back(pb2); if (hb.size() > FL) void'(hb.pop_front());
        fa = filt_next(fa, ha);
        fb = filt_next(fb, hb);
        pa2 = pa1; pa1 = quad_a;
        pb2 = pb1; pb1 = quad_b;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clock or posedge reset);
            if (reset) model_reset();
            else model_edge();
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clock);
        if (cmp_en) begin
            check("step", step, m_step);
            check("dir", dir, m_dir);
            check("position", position, m_pos);
            check("error", error, m_err);
        end
        if (step === 1'b1) step_seen++;
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic set_pins(input logic a, input logic b);
        @(negedge clock);
        quad_a = a; quad_b = b;
    endtask

    task automatic hold_pins(input logic a, input logic b, input int n);
        set_pins(a, b);
        cyc(n - 1);
    endtask

    task automatic do_reset(input logic a, input logic b);
        @(negedge clock);
        quad_a = a; quad_b = b;
        #2 reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    int s0;
    int pidx;
    logic [1:0] pv;

    initial begin
        #1 reset = 1'b1;
        quad_a = 1'b1; quad_b = 1'b1;
        #1 cmp_en = 1'b1;
        cyc(3);
        reset = 1'b0;

        // Pins high through reset: settling absorbed, nothing reported.
        s0 = step_seen;
        cyc(10);
        check("init_no_step", step_seen - s0, 0);
        check("init_error", error, 0);
        check("init_position", position, 0);

        // Four up transitions with counting enabled.
        do_reset(1'b0, 1'b0);
        cyc(10);
        counter_en = 1'b1;
        s0 = step_seen;
        set_pins(1'b1, 1'b0);
        @(posedge clock);           // edge n: first capture
        repeat (4) @(posedge clock);
        #1 check("latency_edge4", step, 0);
        @(posedge clock);
        #1 check("latency_edge5", step, 1);
        cyc(6);
        hold_pins(1'b1, 1'b1, 8);
        hold_pins(1'b0, 1'b1, 8);
        hold_pins(1'b0, 1'b0, 8);
        check("up_steps", step_seen - s0, 4);
        check("up_dir", dir, 1);
        check("up_position", position, 4);

        // Down from zero wraps.
        @(negedge clock); clear = 1'b1;
        @(negedge clock); clear = 1'b0;
        s0 = step_seen;
        hold_pins(1'b0, 1'b1, 8);
        check("wrap_position", position, 8'hFF);
        check("wrap_dir", dir, 0);
        check("wrap_steps", step_seen - s0, 1);

        // Glitch of 2 cycles rejected; 3 cycles accepted.
        s0 = step_seen;
        hold_pins(1'b1, 1'b1, 2);
        hold_pins(1'b0, 1'b1, 8);
        check("glitch_steps", step_seen - s0, 0);
        check("glitch_position", position, 8'hFF);
        hold_pins(1'b1, 1'b1, 10);
        check("filter3_steps", step_seen - s0, 1);
        check("filter3_position", position, 8'hFE);

        // Down twice, then an illegal double flip.
        hold_pins(1'b1, 1'b0, 8);
        hold_pins(1'b0, 1'b0, 8);
        s0 = step_seen;
        hold_pins(1'b1, 1'b1, 8);
        check("illegal_error", error, 1);
        check("illegal_steps", step_seen - s0, 0);
        check("illegal_position", position, 8'hFC);
        @(negedge clock); clear = 1'b1;
        @(negedge clock); clear = 1'b0;
        cyc(1);
        check("clear_error", error, 0);
        check("clear_position", position, 0);

        // One counted up step, then three with counting disabled.
        hold_pins(1'b0, 1'b1, 8);
        counter_en = 1'b0;
        s0 = step_seen;
        hold_pins(1'b0, 1'b0, 8);
        hold_pins(1'b1, 0, 8);
        hold_pins(1'b1, 1'b1, 8);
        check("hold_steps", step_seen - s0, 3);
        check("hold_dir", dir, 1);
        check("hold_position", position, 1);

        // Reset while a filter count is pending.
        set_pins(1'b0, 1'b1);
        cyc(2);
        #2 reset = 1'b1;
        #1;
        check("rst_step", step, 0);
        check("rst_dir", dir, 0);
        check("rst_position", position, 0);
        check("rst_error", error, 0);
        @(negedge clock); reset = 1'b0;
        s0 = step_seen;
        cyc(10);
        check("reinit_no_step", step_seen - s0, 0);

        // Randomized traffic against the model.
        pidx = 3;  // pins currently 01
        for (int it = 0; it < 300; it++) begin
            int r;
            r = int'($urandom_range(0, 99));
            counter_en = ($urandom_range(0, 3) != 0);
            if (r < 45)      pidx = (pidx + 1) % 4;
            else if (r < 90) pidx = (pidx + 3) % 4;
            else if (r < 96) pidx = (pidx + 2) % 4;
            case (pidx)
                0:       pv = 2'b00;
                1:       pv = 2'b10;
                2:       pv = 2'b11;
                default: pv = 2'b01;
            endcase
            if (r == 99) begin
                do_reset(pv[1], pv[0]);
            end else begin
                hold_pins(pv[1], pv[0], int'($urandom_range(1, 10)));
            end
            if ($urandom_range(0, 19) == 0) begin
                @(negedge clock); clear = 1'b1;
                @(negedge clock); clear = 1'b0;
            end
        end
        cyc(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/quad_decoder.md
# quad_decoder

Quadrature decoder that turns the two phase signals of an incremental encoder (A/B) into a one-cycle step pulse, a direction bit and a wrapping position count. It is the producing end of the up/down counting interface: its step/direction pair is exactly the enable/up-down pair an up/down counter consumes, and it also keeps its own position register. It sits between off-chip encoder pins and the counting/readout logic, all in one clock domain.

## Interface
- WIDTH, 8: position counter width in bits.
- FILTER_LEN, 3: consecutive stable synchronized samples a channel needs before its filtered level changes (≥1).
- clock, input, 1: single system clock; all state changes on its rising edge.
- reset, input, 1: asynchronous, active-high; clears all state immediately.
- quad_a, input, 1: encoder phase A, asynchronous to clock.
- quad_b, input, 1: encoder phase B, asynchronous to clock.
- counter_en, input, 1: 1 lets valid steps update position; 0 holds position. step and dir still report.
- clear, input, 1: synchronous; position <= 0 and error <= 0 on the next edge.
- step, output, 1: one-cycle pulse per valid quadrature transition.
- dir, output, 1: direction of the last valid step, 1 = up, 0 = down. Holds between steps.
- position, output, WIDTH: signed-agnostic count, wraps modulo 2^WIDTH.
- error, output, 1: sticky; set on an illegal transition where both filtered phases change in one cycle.

## Operation
- Reset values: step=0, dir=0, position=0, error=0, synchronizers=0, filtered levels=0, filter counters=0, FSM=INIT.
- Per channel, a 2-FF synchronizer feeds a filter. The filter counter increments each cycle that the synchronized level differs from the filtered level, and resets to 0 when they match. When the count would reach FILTER_LEN, the filtered level takes the synchronized value and the counter resets to 0.
- Decode compares the previous filtered state {A,B} with the current one.
  - Up sequence, A leading: 00→10→11→01→00.
  - Down sequence: the reverse.
- On a valid up or down transition, step=1 and dir is set to match. If counter_en=1, position changes by +1 or −1.
- No change: step=0, nothing updates.
- Both bits change: error<=1, step=0, position and dir unchanged. The previous state still loads the new value.
- FSM states:
  - INIT: entered on reset. Lasts FILTER_LEN+3 cycles. The previous-state register tracks the filtered state every cycle. No step and no error are produced. This absorbs the settling of the pins' initial level.
  - RUN: normal decode. Stays in RUN until reset; clear does not re-enter INIT.
- Simultaneous clear and valid step: clear wins, so position=0 and error=0. step and dir still reflect the step.
- Simultaneous clear and illegal transition: clear wins, so error=0.
- Wrap: up from 2^WIDTH−1 gives 0; down from 0 gives 2^WIDTH−1. No flag is raised.
- Reset asserted mid-operation: all outputs go to reset values asynchronously and the FSM returns to INIT.

## Timing
- If a new pin level is first captured by the synchronizer at edge n and then stays stable, the filtered level updates at edge n+1+FILTER_LEN. step, dir and position update at edge n+2+FILTER_LEN.
- Default end-to-end latency is 5 edges.
- A pin pulse shorter than FILTER_LEN cycles (as seen after synchronization) is rejected with no output activity.
- Maximum decodable edge rate: one filtered change per channel every FILTER_LEN+1 cycles. Faster inputs may produce error.
- step is high for exactly one cycle per transition, and position changes on the same edge that step rises.
- Outputs are registered; there are no combinational paths from input to output.

## Structure
- Package quad_pkg contains:
  - FSM state typedef: INIT, RUN.
  - 2-bit phase-state constants: S00, S10, S11, S01.
  - Direction constants: DIR_UP=1, DIR_DOWN=0.
- Sub-module quad_filter: synchronizer plus stability filter for one channel, parameterized by FILTER_LEN, instantiated twice.
- The top level holds the INIT counter, FSM, decode logic, position, dir and error registers.

## Test plan
- Reset with quad_a=1 and quad_b=1, then release and wait 10 cycles → step never pulses, error=0, position=0.
- Apply 4 up transitions (00→10→11→01→00), each held 8 cycles, with counter_en=1 → 4 step pulses, dir=1, position=4. Each pulse occurs at edge n+5 after its change is first captured.
- With position=0, apply one down transition (00→01) → position=255, dir=0, one step pulse.
- Hold quad_a high for 2 cycles in RUN (FILTER_LEN=3) → no step, position unchanged. Hold it for 3 cycles → exactly one step.
- Flip A and B together (00→11) → error=1, no step, position unchanged. Assert clear for one cycle → error=0, position=0.
- Set counter_en=0 and apply 3 up transitions → 3 step pulses with dir=1, position unchanged. Then assert reset during a pending filter count → all outputs go to 0 immediately and the FSM re-runs INIT.
